control_unit_legv8: RTL

Multicycle control unit that sits directly upstream of Datapath_LEGv8 and drives every one of its control inputs. It takes IR_out, status and SR_out back from the datapath and sequences fetch, decode/execute and memory-access cycles for a LEGv8 subset. It handshakes with memory, which shares the datapath's tristate data and address buses.

---
 rtl/legv8_pkg.sv | 50 +++++
 rtl/legv8_cond_check.sv | 34 +++
 rtl/control_unit_legv8.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/legv8_pkg.sv
// Shared decode constants, ALU/PC operation codes and FSM encoding for the LEGv8 multicycle controller.
package legv8_pkg;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [10:0] OP_BR   = 11'b11010110000;

  // FS[1] inverts B, so SUB = ADD with inverted B and C0 = 1.
  localparam logic [4:0] FS_AND   = 5'b00000;
  localparam logic [4:0] FS_ORR   = 5'b00100;
  localparam logic [4:0] FS_ADD   = 5'b01000;
  localparam logic [4:0] FS_SUB   = 5'b01010;
  localparam logic [4:0] FS_EOR   = 5'b01100;
  localparam logic [4:0] FS_PASSB = 5'b10000;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_LOAD = 2'b10;
  localparam logic [1:0] PS_REL  = 2'b11;

  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_HS = 4'h2, COND_LO = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_MEM, ST_HALT} state_t;

  // PC has already been advanced by 4 during FETCH, hence the -4 correction.
  function automatic logic [63:0] rel_imm26(input logic [25:0] imm);
    return {{36{imm[25]}}, imm, 2'b00} - 64'd4;
  endfunction

  function automatic logic [63:0] rel_imm19(input logic [18:0] imm);
    return {{43{imm[18]}}, imm, 2'b00} - 64'd4;
  endfunction

endpackage

// File: rtl/legv8_cond_check.sv
// Evaluates an ARM condition code against latched flags {V,C,N,Z}.
module legv8_cond_check
  import legv8_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       taken_o
);

  logic v, c, n, z;
  assign {v, c, n, z} = flags_i;

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      COND_EQ: taken_o = z;
      COND_NE: taken_o = !z;
      COND_HS: taken_o = c;
      COND_LO: taken_o = !c;
      COND_MI: taken_o = n;
      COND_PL: taken_o = !n;
      COND_VS: taken_o = v;
      COND_VC: taken_o = !v;
      COND_HI: taken_o = c && !z;
      COND_LS: taken_o = !(c && !z);
      COND_GE: taken_o = (n == v);
      COND_LT: taken_o = (n != v);
      COND_GT: taken_o = !z && (n == v);
      COND_LE: taken_o = !(!z && (n == v));
      default: taken_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit_legv8.sv
// Multicycle FETCH/EXEC/MEM controller driving every control input of Datapath_LEGv8.
module control_unit_legv8
  import legv8_pkg::*;
#(
  parameter bit HALT_ON_UNDEF = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] IR_out,
  input  logic [3:0]  status,
  input  logic [3:0]  SR_out,
  input  logic        mem_ready,
  output logic [4:0]  DA,
  output logic [4:0]  SA,
  output logic [4:0]  SB,
  output logic        W,
  output logic [4:0]  FS,
  output logic        C0,
  output logic        IL,
  output logic        SL,
  output logic [1:0]  PS,
  output logic        PCsel,
  output logic        Bsel,
  output logic        EN_ALU,
  output logic        EN_B,
  output logic        EN_PC,
  output logic        EN_ADDR_ALU,
  output logic        EN_ADDR_PC,
  output logic [63:0] constant,
  output logic        mem_read,
  output logic        mem_write,
  output logic        halt
);

  state_t      state_q, state_d;
  logic [10:0] op;
  logic        bcond_taken;
  logic        is_rtype, is_imm, is_mem, is_cb;
  logic        unused_status;

  assign op            = IR_out[31:21];
  assign unused_status = ^status[3:1];
  assign is_rtype = op inside {OP_ADD, OP_ADDS, OP_SUB, OP_SUBS, OP_AND, OP_ORR, OP_EOR};
  assign is_imm   = (op[10:1] == OP_ADDI) || (op[10:1] == OP_SUBI);
  assign is_mem   = (op == OP_LDUR) || (op == OP_STUR);
  assign is_cb    = (op[10:3] == OP_CBZ) || (op[10:3] == OP_CBNZ);

  legv8_cond_check u_cond (
    .cond_i  (IR_out[3:0]),
    .flags_i (SR_out),
    .taken_o (bcond_taken)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  // Outputs are gated by reset directly so strobes fall the instant reset asserts.
  always_comb begin
    state_d     = state_q;
    DA          = '0;
    SA          = '0;
    SB          = '0;
    W           = 1'b0;
    FS          = FS_AND;
    C0          = 1'b0;
    IL          = 1'b0;
    SL          = 1'b0;
    PS          = PS_HOLD;
    PCsel       = 1'b0;
    Bsel        = 1'b0;
    EN_ALU      = 1'b0;
    EN_B        = 1'b0;
    EN_PC       = 1'b0;
    EN_ADDR_ALU = 1'b0;
    EN_ADDR_PC  = 1'b0;
    constant    = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    halt        = 1'b0;
    if (reset) begin
      case (state_q)
        ST_FETCH: begin
          EN_ADDR_PC = 1'b1;
          mem_read   = 1'b1;
          if (mem_ready) begin
            IL      = 1'b1;
            PS      = PS_INC;
            state_d = ST_EXEC;
          end
        end
        ST_EXEC: begin
          state_d = ST_FETCH;
          if (is_rtype || is_imm) begin
            SA     = IR_out[9:5];
            SB     = IR_out[20:16];
            DA     = IR_out[4:0];
            EN_ALU = 1'b1;
            W      = 1'b1;
            SL     = (op == OP_ADDS) || (op == OP_SUBS);
            if (is_imm) begin
              Bsel     = 1'b1;
              constant = {52'd0, IR_out[21:10]};
              FS       = (op[10:1] == OP_SUBI) ? FS_SUB : FS_ADD;
              C0       = (op[10:1] == OP_SUBI);
            end else begin
              case (op)
                OP_ADD, OP_ADDS: FS = FS_ADD;
                OP_SUB, OP_SUBS: begin FS = FS_SUB; C0 = 1'b1; end
                OP_ORR:          FS = FS_ORR;
                OP_EOR:          FS = FS_EOR;
                default:         FS = FS_AND;
              endcase
            end
          end else if (is_mem) begin
            state_d = ST_MEM;
          end else if (op[10:5] == OP_B) begin
            constant = rel_imm26(IR_out[25:0]);
            PCsel    = 1'b1;
            PS       = PS_REL;
          end else if (is_cb) begin
            SB       = IR_out[4:0];
            FS       = FS_PASSB;
            constant = rel_imm19(IR_out[23:5]);
            PCsel    = 1'b1;
            if (status[0] != IR_out[24]) PS = PS_REL;
          end else if (op[10:3] == OP_BCOND) begin
            constant = rel_imm19(IR_out[23:5]);
            PCsel    = 1'b1;
            if (bcond_taken) PS = PS_REL;
          end else if (op == OP_BR) begin
            SA = IR_out[9:5];
            PS = PS_LOAD;
          end else if (HALT_ON_UNDEF) begin
            state_d = ST_HALT;
          end
        end
        ST_MEM: begin
          SA          = IR_out[9:5];
          constant    = {{55{IR_out[20]}}, IR_out[20:12]};
          Bsel        = 1'b1;
          FS          = FS_ADD;
          EN_ADDR_ALU = 1'b1;
          if (op == OP_LDUR) begin
            DA       = IR_out[4:0];
            mem_read = 1'b1;
            W        = mem_ready;
          end else begin
            SB        = IR_out[4:0];
            EN_B      = 1'b1;
            mem_write = 1'b1;
          end
          if (mem_ready) state_d = ST_FETCH;
        end
        ST_HALT: halt = 1'b1;
        default: state_d = ST_FETCH;
      endcase
    end
  end

endmodule
